store_merge_unit: RTL and testbench

Sequential store-path unit for the single-cycle datapath's data-memory port. It is the write-side counterpart of the load-path sign extension: it truncates a 32-bit register value to byte, halfword or word width. It then places the result in the correct byte lane of the addressed memory word. Sub-word stores are done by read-modify-write against a word-wide synchronous data memory, under a valid/ready request handshake.

---
 rtl/store_merge_unit.sv | 123 ++++++++++++
 tb/tb_store_merge_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store path for the data-memory port: truncates a register value to byte, half
// or word, and merges sub-word stores into the addressed word by read-modify-write.
module store_merge_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rd_data,
  output logic [31:0]           mem_wr_data,
  output logic                  done,
  output logic                  misaligned
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state, state_next;
  logic        accept;
  logic        illegal;
  logic [1:0]  lane_q;
  logic [15:0] data_q;
  logic [1:0]  size_q;
  logic [31:0] merged;

  assign req_ready = (state == ST_IDLE) && !Reset;
  assign accept    = req_valid && req_ready;

  // Moore outputs: each strobe belongs to exactly one state, so the
  // mutual-exclusion rules between strobes hold by construction.
  assign mem_rd_en  = (state == ST_READ);
  assign mem_wr_en  = (state == ST_WRITE);
  assign done       = (state == ST_WRITE);
  assign misaligned = (state == ST_ERR);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    illegal = 1'b0;
    case (req_size)
      SIZE_BYTE: illegal = 1'b0;
      SIZE_HALF: illegal = req_addr[0];
      SIZE_WORD: illegal = |req_addr[1:0];
      default:   illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (illegal)                    state_next = ST_ERR;
          else if (req_size == SIZE_WORD) state_next = ST_WRITE;
          else                            state_next = ST_READ;
        end
      end
      ST_READ:  state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_WRITE;
      ST_WRITE: state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Little-endian lane replacement over the word returned by the read.
  always_comb begin
    merged = mem_rd_data;
    case (size_q)
      SIZE_BYTE: begin
        case (lane_q)
          2'd0:    merged[7:0]   = data_q[7:0];
          2'd1:    merged[15:8]  = data_q[7:0];
          2'd2:    merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (lane_q[1]) merged[31:16] = data_q;
        else           merged[15:0]  = data_q;
      end
      default: merged = mem_rd_data;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state       <= ST_IDLE;
      lane_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      state <= state_next;
      if (accept && !illegal) begin
        lane_q   <= req_addr[1:0];
        data_q   <= req_data[15:0];
        size_q   <= req_size;
        mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (req_size == SIZE_WORD) mem_wr_data <= req_data;
      end
      if (state == ST_WAIT) mem_wr_data <= merged;
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: sub-word merges, word stores, rejections,
// reset mid-operation and back-to-back requests with a one-word memory model.
module tb_store_merge_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        misaligned;

  logic [31:0] rd_word;
  int          errors = 0;
  int          checks = 0;

  store_merge_unit #(.ADDR_WIDTH(32)) dut (
    .Clk         (clk),
    .Reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory returning the current test's word one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= rd_word;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  // Sub-word store: read in cycle 1, idle bus in cycle 2, write in cycle 3, ready in cycle 4.
  task automatic sub_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic [31:0] mem_word,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
    rd_word = mem_word;
    request(a, d, s);
    tick();
    req_valid = 1'b0;
    req_data  = 32'h5A5A_5A5A;
    check({tag, "_c1_rd_en"}, mem_rd_en, 1);
    check({tag, "_c1_addr"},  mem_addr, exp_addr);
    check({tag, "_c1_wr_en"}, mem_wr_en, 0);
    check({tag, "_c1_ready"}, req_ready, 0);
    tick();
    check({tag, "_c2_rd_en"}, mem_rd_en, 0);
    check({tag, "_c2_wr_en"}, mem_wr_en, 0);
    tick();
    check({tag, "_c3_wr_en"}, mem_wr_en, 1);
    check({tag, "_c3_done"},  done, 1);
    check({tag, "_c3_rd_en"}, mem_rd_en, 0);
    check({tag, "_c3_addr"},  mem_addr, exp_addr);
    check({tag, "_c3_data"},  mem_wr_data, exp_data);
    tick();
    check({tag, "_c4_ready"}, req_ready, 1);
    check({tag, "_c4_done"},  done, 0);
  endtask

  task automatic rejected(input string tag, input logic [31:0] a, input logic [1:0] s);
    request(a, 32'h1234_5678, s);
    tick();
    req_valid = 1'b0;
    check({tag, "_misaligned"}, misaligned, 1);
    check({tag, "_rd_en"},      mem_rd_en, 0);
    check({tag, "_wr_en"},      mem_wr_en, 0);
    check({tag, "_done"},       done, 0);
    tick();
    check({tag, "_mis_drop"},   misaligned, 0);
    check({tag, "_ready"},      req_ready, 1);
    check({tag, "_wr_en2"},     mem_wr_en, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = '0;
    rd_word   = '0;

    tick();
    tick();
    check("rst_ready",   req_ready, 0);
    check("rst_rd_en",   mem_rd_en, 0);
    check("rst_wr_en",   mem_wr_en, 0);
    check("rst_done",    done, 0);
    check("rst_mis",     misaligned, 0);
    check("rst_addr",    mem_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", req_ready, 1);

    sub_store("sb_lane1", 32'h1001, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 32'h1000, 32'h1122_AB44);
    sub_store("sh_hi",    32'h2002, 32'h0000_BEEF, 2'b01, 32'hCAFE_1234, 32'h2000, 32'hBEEF_1234);
    sub_store("sh_lo",    32'h2000, 32'h0000_BEEF, 2'b01, 32'hCAFE_1234, 32'h2000, 32'hCAFE_BEEF);
    sub_store("sb_lane3", 32'h1003, 32'h0000_0099, 2'b00, 32'h1122_3344, 32'h1000, 32'h9922_3344);
    sub_store("sb_lane0", 32'h1000, 32'h0000_0066, 2'b00, 32'h1122_3344, 32'h1000, 32'h1122_3366);

    // Word store bypasses the read entirely.
    request(32'h3000, 32'hDEAD_BEEF, 2'b10);
    tick();
    req_valid = 1'b0;
    check("sw_c1_wr_en", mem_wr_en, 1);
    check("sw_c1_done",  done, 1);
    check("sw_c1_rd_en", mem_rd_en, 0);
    check("sw_c1_addr",  mem_addr, 32'h3000);
    check("sw_c1_data",  mem_wr_data, 32'hDEAD_BEEF);
    tick();
    check("sw_c2_ready", req_ready, 1);
    check("sw_c2_rd_en", mem_rd_en, 0);
    check("sw_c2_wr_en", mem_wr_en, 0);

    rejected("err_half_odd",  32'h2003, 2'b01);
    rejected("err_word_mis",  32'h3002, 2'b10);
    rejected("err_size_11",   32'h4000, 2'b11);

    // Reset asserted during the WAIT cycle abandons the pending write.
    rd_word = 32'h1122_3344;
    request(32'h1001, 32'h0000_00AB, 2'b00);
    tick();
    req_valid = 1'b0;
    check("rmid_c1_rd_en", mem_rd_en, 1);
    tick();
    reset = 1'b1;
    tick();
    check("rmid_wr_en",   mem_wr_en, 0);
    check("rmid_done",    done, 0);
    check("rmid_rd_en",   mem_rd_en, 0);
    check("rmid_mis",     misaligned, 0);
    check("rmid_addr",    mem_addr, 0);
    check("rmid_wr_data", mem_wr_data, 0);
    check("rmid_ready",   req_ready, 0);
    tick();
    check("rmid_wr_en2",  mem_wr_en, 0);
    reset = 1'b0;
    #1;
    check("rmid_release_ready", req_ready, 1);
    tick();
    check("rmid_idle_wr_en", mem_wr_en, 0);
    check("rmid_idle_done",  done, 0);

    // Back-to-back with req_valid held high.
    rd_word = 32'h0000_0000;
    request(32'h10, 32'h0000_007F, 2'b00);
    tick();
    request(32'h14, 32'h0102_0304, 2'b10);
    check("b2b_c1_rd_en", mem_rd_en, 1);
    check("b2b_c1_addr",  mem_addr, 32'h10);
    check("b2b_c1_ready", req_ready, 0);
    tick();
    check("b2b_c2_wr_en", mem_wr_en, 0);
    tick();
    check("b2b_c3_wr_en", mem_wr_en, 1);
    check("b2b_c3_addr",  mem_addr, 32'h10);
    check("b2b_c3_data",  mem_wr_data, 32'h0000_007F);
    check("b2b_c3_ready", req_ready, 0);
    tick();
    check("b2b_c4_ready", req_ready, 1);
    check("b2b_c4_wr_en", mem_wr_en, 0);
    tick();
    req_valid = 1'b0;
    check("b2b_c5_wr_en", mem_wr_en, 1);
    check("b2b_c5_done",  done, 1);
    check("b2b_c5_rd_en", mem_rd_en, 0);
    check("b2b_c5_addr",  mem_addr, 32'h14);
    check("b2b_c5_data",  mem_wr_data, 32'h0102_0304);
    tick();
    check("b2b_c6_ready", req_ready, 1);
    check("b2b_c6_wr_en", mem_wr_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
